// File: rtl/sound_pkg.sv
// Shared widths, default geometry and FSM state type for the sound playout path.
package sound_pkg;

  localparam int unsigned PTR_W           = 9;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned SAMPLE_W        = 16;
  localparam int unsigned DEF_DEPTH_WORDS = 500;
  localparam int unsigned DEF_START_FILL  = 64;
  localparam int unsigned DEF_RD_LAT      = 2;

  typedef enum logic [1:0] {
    ST_PRIME,
    ST_IDLE,
    ST_FETCH,
    ST_LATCH
  } play_state_e;

endpackage

// File: rtl/sound_playout_if.sv
// Playout bundle: control inputs, sample-store read port and audio-side outputs.
interface sound_playout_if;

  logic                             enable;
  logic                             sample_en;
  logic [sound_pkg::PTR_W-1:0]      wr_word_ptr;
  logic [sound_pkg::PTR_W-1:0]      rdaddress;
  logic [sound_pkg::DATA_W-1:0]     q;
  logic [sound_pkg::SAMPLE_W-1:0]   sample_l;
  logic [sound_pkg::SAMPLE_W-1:0]   sample_r;
  logic                             sample_valid;
  logic                             underrun;
  logic                             late;
  logic [sound_pkg::PTR_W-1:0]      fill_level;

  modport master (
    input  enable, sample_en, wr_word_ptr, q,
    output rdaddress, sample_l, sample_r, sample_valid, underrun, late, fill_level
  );

  modport slave (
    output enable, sample_en, wr_word_ptr, q,
    input  rdaddress, sample_l, sample_r, sample_valid, underrun, late, fill_level
  );

endinterface

// File: rtl/sound_ring_fill.sv
// Words available between reader and writer pointers in a DEPTH_WORDS ring.
module sound_ring_fill
  import sound_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] fill
);

  localparam int unsigned SUM_W = PTR_W + 1;

  logic [PTR_W:0] wrapped;

  always_comb begin
    wrapped = {1'b0, wr_ptr} + SUM_W'(DEPTH_WORDS) - {1'b0, rd_ptr};
    if (wr_ptr >= rd_ptr) begin
      fill = wr_ptr - rd_ptr;
    end else begin
      fill = wrapped[PTR_W-1:0];
    end
  end

endmodule

// File: rtl/sound_playout.sv
// Reads stereo words from the receive ring and presents one sample pair per sample_en strobe.
module sound_playout
  import sound_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned START_FILL  = DEF_START_FILL,
  parameter int unsigned RD_LAT      = DEF_RD_LAT
) (
  input logic            clock,
  input logic            reset,
  sound_playout_if.master bus
);

  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  play_state_e          state_q, state_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     rdaddr_q, rdaddr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]  sample_l_q, sample_l_d;
  logic [SAMPLE_W-1:0]  sample_r_q, sample_r_d;
  logic                 valid_q, valid_d;
  logic                 underrun_q, underrun_d;
  logic                 late_q, late_d;
  logic                 dry_q, dry_d;
  logic [PTR_W-1:0]     fill_q, fill_d;
  logic [PTR_W-1:0]     fill_w;

  sound_ring_fill #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_fill (
    .wr_ptr (bus.wr_word_ptr),
    .rd_ptr (rd_ptr_q),
    .fill   (fill_w)
  );

  // An empty-ring strobe still walks FETCH/LATCH (dry_q set) so that
  // sample_valid keeps the same latency as a real fetch.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    rdaddr_d   = rdaddr_q;
    cnt_d      = cnt_q;
    sample_l_d = sample_l_q;
    sample_r_d = sample_r_q;
    valid_d    = 1'b0;
    underrun_d = 1'b0;
    late_d     = late_q;
    dry_d      = dry_q;
    fill_d     = fill_w;

    if (!bus.enable) begin
      state_d  = ST_PRIME;
      rd_ptr_d = bus.wr_word_ptr;
      late_d   = 1'b0;
      dry_d    = 1'b0;
    end else begin
      case (state_q)
        ST_PRIME: begin
          if (fill_q >= PTR_W'(START_FILL)) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (bus.sample_en) begin
            state_d = ST_FETCH;
            cnt_d   = '0;
            if (fill_q != '0) begin
              rdaddr_d = rd_ptr_q;
              dry_d    = 1'b0;
            end else begin
              underrun_d = 1'b1;
              dry_d      = 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (bus.sample_en) late_d = 1'b1;
          if (cnt_q == CNT_W'(RD_LAT - 1)) begin
            state_d = ST_LATCH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_LATCH: begin
          if (bus.sample_en) late_d = 1'b1;
          if (!dry_q) begin
            sample_l_d = bus.q[SAMPLE_W-1:0];
            sample_r_d = bus.q[DATA_W-1:SAMPLE_W];
            rd_ptr_d   = (rd_ptr_q == PTR_W'(DEPTH_WORDS - 1)) ? '0 : rd_ptr_q + 1'b1;
          end
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_PRIME;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_PRIME;
      rd_ptr_q   <= '0;
      rdaddr_q   <= '0;
      cnt_q      <= '0;
      sample_l_q <= '0;
      sample_r_q <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      late_q     <= 1'b0;
      dry_q      <= 1'b0;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      rdaddr_q   <= rdaddr_d;
      cnt_q      <= cnt_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      late_q     <= late_d;
      dry_q      <= dry_d;
      fill_q     <= fill_d;
    end
  end

  assign bus.rdaddress    = rdaddr_q;
  assign bus.sample_l     = sample_l_q;
  assign bus.sample_r     = sample_r_q;
  assign bus.sample_valid = valid_q;
  assign bus.underrun     = underrun_q;
  assign bus.late         = late_q;
  assign bus.fill_level   = fill_q;

endmodule

// File: tb/tb_sound_playout.sv
// Randomized bench for sound_playout against a ring/pointer reference model.
module tb_sound_playout;

  localparam int unsigned DEPTH = 500;

  logic clock;
  logic reset;

  sound_playout_if bus ();

  sound_playout #(
    .DEPTH_WORDS(DEPTH),
    .START_FILL (64),
    .RD_LAT     (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sample store with two cycles from rdaddress to q.
  logic [31:0] mem [DEPTH];
  logic [8:0]  addr_d1;
  always @(posedge clock) begin
    addr_d1 <= bus.rdaddress;
    bus.q   <= mem[addr_d1];
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned m_rd, m_wr;
  bit          m_primed, m_late;
  logic [31:0] m_last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned m_fill();
    return (m_wr + DEPTH - m_rd) % DEPTH;
  endfunction

  task automatic advance(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      mem[m_wr] = $urandom;
      m_wr = (m_wr + 1) % DEPTH;
    end
    @(negedge clock);
    bus.wr_word_ptr = 9'(m_wr);
    repeat (3) @(negedge clock);
    if (!m_primed && m_fill() >= 64) m_primed = 1'b1;
    check_eq("fill_after_write", 32'(bus.fill_level), m_fill());
  endtask

  // late_at: 0 = no extra strobe, 1..3 = extra strobe that many cycles after the first.
  task automatic strobe(input int unsigned late_at);
    bit          normal, dry;
    logic [31:0] exp_pair;
    int unsigned exp_addr;
    normal   = m_primed && (m_fill() != 0);
    dry      = m_primed && (m_fill() == 0);
    exp_pair = normal ? mem[m_rd] : m_last;
    exp_addr = m_rd;
    @(negedge clock);
    bus.sample_en = 1'b1;
    for (int unsigned c = 1; c <= 6; c++) begin
      @(negedge clock);
      bus.sample_en = normal && (c == late_at);
      check_eq($sformatf("valid_c%0d", c), 32'(bus.sample_valid), 32'((c == 4) && m_primed));
      check_eq($sformatf("underrun_c%0d", c), 32'(bus.underrun), 32'((c == 1) && dry));
      if (c == 1 && normal) check_eq("rdaddress", 32'(bus.rdaddress), exp_addr);
      if (c == 4 && m_primed) begin
        check_eq("sample_l", 32'(bus.sample_l), 32'(exp_pair[15:0]));
        check_eq("sample_r", 32'(bus.sample_r), 32'(exp_pair[31:16]));
      end
    end
    if (normal) begin
      m_rd   = (m_rd + 1) % DEPTH;
      m_last = exp_pair;
      if (late_at != 0) m_late = 1'b1;
    end
    check_eq("late", 32'(bus.late), 32'(m_late));
    check_eq("fill_after_strobe", 32'(bus.fill_level), m_fill());
  endtask

  task automatic flush(input int unsigned target);
    @(negedge clock);
    bus.enable      = 1'b0;
    m_wr            = target;
    bus.wr_word_ptr = 9'(target);
    repeat (2) begin
      @(negedge clock);
      check_eq("flush_valid", 32'(bus.sample_valid), 32'd0);
    end
    bus.enable = 1'b1;
    m_rd     = target;
    m_primed = 1'b0;
    m_late   = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("flush_late", 32'(bus.late), 32'd0);
    check_eq("flush_fill", 32'(bus.fill_level), 32'd0);
  endtask

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = $urandom;
    reset           = 1'b0;
    bus.enable      = 1'b1;
    bus.sample_en   = 1'b0;
    bus.wr_word_ptr = '0;
    repeat (3) @(negedge clock);
    check_eq("rst_rdaddress", 32'(bus.rdaddress), 32'd0);
    check_eq("rst_sample_l", 32'(bus.sample_l), 32'd0);
    check_eq("rst_sample_r", 32'(bus.sample_r), 32'd0);
    check_eq("rst_valid", 32'(bus.sample_valid), 32'd0);
    check_eq("rst_underrun", 32'(bus.underrun), 32'd0);
    check_eq("rst_late", 32'(bus.late), 32'd0);
    check_eq("rst_fill", 32'(bus.fill_level), 32'd0);
    reset = 1'b1;
    m_rd = 0; m_wr = 0; m_primed = 1'b0; m_late = 1'b0; m_last = '0;

    // Priming threshold: 63 words is not enough, 64 is.
    advance(63);
    strobe(0);
    advance(1);
    mem[0] = 32'hBEEF_1234;
    strobe(0);
    check_eq("first_l", 32'(bus.sample_l), 32'h1234);
    check_eq("first_r", 32'(bus.sample_r), 32'hBEEF);

    // Second strobe one cycle after the first.
    strobe(1);
    check_eq("late_set", 32'(bus.late), 32'd1);
    strobe(3);

    // Enable dropped mid-fetch: fetch abandoned, reader jumps to writer.
    @(negedge clock);
    bus.sample_en = 1'b1;
    @(negedge clock);
    bus.sample_en   = 1'b0;
    bus.enable      = 1'b0;
    bus.wr_word_ptr = 9'd200;
    @(negedge clock);
    bus.enable = 1'b1;
    m_wr = 200; m_rd = 200; m_primed = 1'b0; m_late = 1'b0;
    for (int unsigned c = 0; c < 6; c++) begin
      @(negedge clock);
      check_eq("abandon_valid", 32'(bus.sample_valid), 32'd0);
    end
    check_eq("abandon_late", 32'(bus.late), 32'd0);
    check_eq("abandon_fill", 32'(bus.fill_level), 32'd0);
    advance(64);
    strobe(0);

    // Ring wrap of the read pointer.
    flush(430);
    advance(80);
    while (m_rd != 499) strobe(0);
    check_eq("wrap_fill_pre", 32'(bus.fill_level), 32'd11);
    strobe(0);
    check_eq("wrap_rd_zero", 32'(m_rd), 32'd0);
    check_eq("wrap_fill_post", 32'(bus.fill_level), 32'd10);

    // Drain to empty, then an underrun strobe that repeats the last pair.
    while (m_rd != m_wr) strobe($urandom_range(0, 3));
    strobe(0);
    check_eq("under_hold_l", 32'(bus.sample_l), 32'(m_last[15:0]));

    for (int unsigned it = 0; it < 200; it++) begin
      int unsigned r;
      r = $urandom_range(0, 11);
      if (r == 0) begin
        flush($urandom_range(0, DEPTH - 1));
      end else if (r <= 3) begin
        int unsigned n;
        n = $urandom_range(1, 80);
        if (m_fill() + n > DEPTH - 1) n = DEPTH - 1 - m_fill();
        if (n != 0) advance(n);
      end else begin
        strobe(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
